// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses pll_rst, qualifies synced lock, releases domain resets in staggered order.
// Latency: lock -> lock_s 2 clkin edges; all outputs registered, one edge after the deciding lock_s sample.
// No backpressure; free-running on clkin. Optional lock-timeout retry enabled by macro PLL_RETRY_EN.
module pll_rst_seq #(
    parameter int NUM_DOMAINS    = 3,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES = 16,
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65536
) (
    input  logic                   clkin,
    input  logic                   rst,
    input  logic                   lock,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   ready,
    output logic                   lock_lost,
    output logic [7:0]             relock_cnt
);

    localparam int MAX_A = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int MAXP  = (MAX_A > PLL_RST_CYCLES) ? MAX_A : PLL_RST_CYCLES;
    localparam int CNT_W = $clog2(MAXP) + 1;

    localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST    = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_RST = '1;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [NUM_DOMAINS-1:0] rst_out_nxt;
    logic                   lock_lost_nxt;
    logic [7:0]             relock_nxt;
    logic                   lock_meta, lock_s;
    logic                   lose;

`ifdef PLL_RETRY_EN
    localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

    // Two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock;
            lock_s    <= lock_meta;
        end
    end

    assign lose = !lock_s && (state == ST_STABLE || state == ST_RELEASE || state == ST_RUN);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rst_out_nxt   = rst_out;
        lock_lost_nxt = 1'b0;
        relock_nxt    = relock_cnt;
`ifdef PLL_RETRY_EN
        tmo_cnt_nxt   = tmo_cnt;
`endif
        if (lose) begin
            state_nxt     = ST_WAIT_LOCK;
            cnt_nxt       = '0;
            rst_out_nxt   = ALL_RST;
            lock_lost_nxt = 1'b1;
            if (relock_cnt != 8'hFF) begin
                relock_nxt = relock_cnt + 8'd1;
            end
`ifdef PLL_RETRY_EN
            tmo_cnt_nxt   = '0;
`endif
        end else begin
            case (state)
                ST_PLL_RST: begin
                    rst_out_nxt = ALL_RST;
                    if (cnt == PRST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                        cnt_nxt   = '0;
`ifdef PLL_RETRY_EN
                        tmo_cnt_nxt = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    rst_out_nxt = ALL_RST;
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                        cnt_nxt   = '0;
`ifdef PLL_RETRY_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Lock never came: kick the PLL again, loss count untouched
                        state_nxt = ST_PLL_RST;
                        cnt_nxt   = '0;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
`endif
                    end
                end
                ST_STABLE: begin
                    if (cnt == STABLE_LAST) begin
                        state_nxt   = ST_RELEASE;
                        cnt_nxt     = '0;
                        rst_out_nxt = ALL_RST << 1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // rst_out is a thermometer: each stagger step shifts in one more released bit
                    if (rst_out == '0) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else if (cnt == STG_LAST) begin
                        rst_out_nxt = rst_out << 1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_out_nxt = '0;
                end
                default: begin
                    state_nxt   = ST_PLL_RST;
                    cnt_nxt     = '0;
                    rst_out_nxt = ALL_RST;
                end
            endcase
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state      <= ST_PLL_RST;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            rst_out    <= ALL_RST;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pll_rst    <= (state_nxt == ST_PLL_RST);
            rst_out    <= rst_out_nxt;
            ready      <= (state_nxt == ST_RUN);
            lock_lost  <= lock_lost_nxt;
            relock_cnt <= relock_nxt;
        end
    end

`ifdef PLL_RETRY_EN
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: random lock stimulus against a sample-count timeline model.
module tb_pll_rst_seq;

    localparam int N  = 3;
    localparam int SC = 8;
    localparam int SG = 4;
    localparam int PR = 4;
    localparam int LT = 32;
`ifdef PLL_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic         clkin = 1'b0;
    logic         rst;
    logic         lock;
    logic         pll_rst;
    logic [N-1:0] rst_out;
    logic         ready;
    logic         lock_lost;
    logic [7:0]   relock_cnt;

    always #5 clkin = ~clkin;

    pll_rst_seq #(
        .NUM_DOMAINS(N), .STABLE_CYCLES(SC), .STAGGER_CYCLES(SG),
        .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT(LT)
    ) dut (
        .clkin(clkin), .rst(rst), .lock(lock), .pll_rst(pll_rst),
        .rst_out(rst_out), .ready(ready), .lock_lost(lock_lost), .relock_cnt(relock_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: pulse cycles left, consecutive lock_s=1 samples since waiting began,
    // zero samples while waiting, loss count, loss pulse, 2-deep lock delay line.
    int m_pulse, m_k, m_w, m_relock;
    bit m_lost, m_s1, m_s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pulse = PR; m_k = 0; m_w = 0; m_relock = 0;
        m_lost = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endfunction

    function automatic void model_step();
        bit s;
        s = m_s2;
        m_s2 = m_s1;
        m_s1 = lock;
        m_lost = 1'b0;
        if (m_pulse > 0) begin
            m_pulse--;
        end else if (s) begin
            m_k++;
            m_w = 0;
        end else if (m_k > 0) begin
            m_k = 0;
            m_w = 0;
            m_lost = 1'b1;
            if (m_relock < 255) m_relock++;
        end else begin
            m_w++;
            if (RETRY && m_w == LT) begin
                m_pulse = PR;
                m_w = 0;
            end
        end
    endfunction

    // One sample enters STABLE, SC more reach RELEASE; r counts cycles since RELEASE entry.
    function automatic logic [N-1:0] exp_rst_out();
        logic [N-1:0] v;
        int r, rel;
        v = '1;
        if (m_pulse > 0 || m_k < SC + 1) return v;
        r = m_k - SC - 1;
        rel = r / SG + 1;
        if (rel > N) rel = N;
        v = v << rel;
        return v;
    endfunction

    function automatic logic exp_ready();
        if (m_pulse > 0 || m_k < SC + 1) return 1'b0;
        return (m_k - SC - 1) >= (N - 1) * SG + 1;
    endfunction

    task automatic tick();
        @(posedge clkin);
        model_step();
        #1;
        check("pll_rst", pll_rst, m_pulse > 0);
        check("rst_out", rst_out, exp_rst_out());
        check("ready", ready, exp_ready());
        check("lock_lost", lock_lost, m_lost);
        check("relock_cnt", relock_cnt, m_relock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_rst"}, pll_rst, 1);
        check({tag, "_rst_out"}, rst_out, 3'b111);
        check({tag, "_ready"}, ready, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        check({tag, "_relock"}, relock_cnt, 0);
    endtask

    task automatic apply_reset();
        @(negedge clkin);
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_vals("rst");
        @(negedge clkin);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        lock = 1'b0;
        model_reset();
        #1;
        check_reset_vals("init");
        @(negedge clkin);
        rst = 1'b0;

        // Clean bring-up with lock held high
        lock = 1'b1;
        repeat (50) tick();
        check("bringup_ready", ready, 1);

        // Lose lock, relock, then glitch low partway through the stable count
        lock = 1'b0;
        repeat (4) tick();
        lock = 1'b1;
        n = 0;
        while (m_k != 6 && n < 50) begin
            tick();
            n++;
        end
        check("glitch_reached", n < 50, 1);
        lock = 1'b0;
        tick();
        lock = 1'b1;
        repeat (30) tick();
        check("relock_ready", ready, 1);

        // Random lock activity
        repeat (40) begin
            lock = 1'b1;
            repeat ($urandom_range(1, 30)) tick();
            lock = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
        end

        // Lock absent for a long time: retry pulses only when enabled
        lock = 1'b0;
        repeat (100) tick();

        // Many losses to exercise saturation
        apply_reset();
        lock = 1'b1;
        repeat (10) tick();
        repeat (300) begin
            lock = 1'b1;
            tick();
            lock = 1'b0;
            tick();
        end
        check("relock_sat", relock_cnt, 255);

        // Asynchronous reset during staggered release
        apply_reset();
        lock = 1'b1;
        n = 0;
        while (exp_rst_out() != 3'b100 && n < 100) begin
            tick();
            n++;
        end
        check("release_mid", rst_out, 3'b100);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_vals("async");
        @(negedge clkin);
        rst = 1'b0;
        repeat (40) tick();
        check("final_ready", ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
